// File: rtl/branch_target_unit.sv
// -----------------------------------------------------------------------------
// branch_target_unit
//
// Computes a branch/jump target from a single request and holds it in a
// one-entry output register with a valid/ready handshake on both sides.
//
//   mode 0 (PC-relative): target = pc_plus4 + (sign-extended offset << SHIFT)
//   mode 1 (absolute)   : target = zero-extended offset << SHIFT
//   The result is truncated to ADDR_W bits.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  unit can accept a request this cycle
//   mode       in   0 = PC-relative branch, 1 = absolute jump
//   pc_plus4   in   [ADDR_W-1:0] PC + 4 of the branch
//   offset     in   [OFF_W-1:0]  raw immediate
//   out_valid  out  target holds a valid result
//   out_ready  in   consumer accepts the result this cycle
//   target     out  [ADDR_W-1:0] computed target
//   wrap       out  result did not fit in ADDR_W bits
//   req_count  out  [15:0] results accepted by the consumer since reset
//
// Configuration
//   BTU_WRAP_DETECT_EN : when defined, wrap is computed and registered with
//                        target; when undefined, wrap is tied to 0 and the
//                        detection logic is absent.
// -----------------------------------------------------------------------------
module branch_target_unit #(
    parameter int ADDR_W = 10,
    parameter int OFF_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [OFF_W-1:0]  offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] target,
    output logic              wrap,
    output logic [15:0]       req_count
);

    // Wide enough that neither the relative sum nor the shifted absolute
    // value can overflow, so the upper bits tell the true range.
    localparam int SUM_W = ADDR_W + OFF_W + SHIFT + 1;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] target_q,    target_d;
    logic [15:0]       req_count_q, req_count_d;

    logic              in_xfer;
    logic              out_xfer;
    logic [SUM_W-1:0]  off_sext;
    logic [SUM_W-1:0]  off_zext;
    logic [SUM_W-1:0]  rel_sum;
    logic [SUM_W-1:0]  abs_val;
    logic [SUM_W-1:0]  result;

    // A full register can still accept when it is being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        off_sext = {{(SUM_W-OFF_W){offset[OFF_W-1]}}, offset};
        off_zext = {{(SUM_W-OFF_W){1'b0}}, offset};
        rel_sum  = {{(SUM_W-ADDR_W){1'b0}}, pc_plus4} + (off_sext << SHIFT);
        abs_val  = off_zext << SHIFT;
        result   = mode ? abs_val : rel_sum;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        target_d    = target_q;
        req_count_d = req_count_q;
        if (out_xfer) begin
            req_count_d = req_count_q + 16'd1;
            out_valid_d = 1'b0;
        end
        // Loading takes priority over draining so back-to-back stays valid.
        if (in_xfer) begin
            out_valid_d = 1'b1;
            target_d    = result[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            target_q    <= '0;
            req_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            target_q    <= target_d;
            req_count_q <= req_count_d;
        end
    end

`ifdef BTU_WRAP_DETECT_EN
    logic wrap_q, wrap_d;

    // Any set bit above ADDR_W means the value is out of range; for a
    // negative relative sum the sign extension makes those bits non-zero.
    always_comb begin
        wrap_d = wrap_q;
        if (in_xfer) begin
            wrap_d = |result[SUM_W-1:ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign target    = target_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_branch_target_unit.sv
module tb_branch_target_unit;

    localparam int ADDR_W = 10;
    localparam int OFF_W  = 16;
    localparam int SHIFT  = 2;
`ifdef BTU_WRAP_DETECT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [ADDR_W-1:0] pc_plus4;
    logic [OFF_W-1:0]  offset;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] target;
    logic              wrap;
    logic [15:0]       req_count;

    int errors = 0;
    int checks = 0;

    branch_target_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .pc_plus4(pc_plus4), .offset(offset),
        .out_valid(out_valid), .out_ready(out_ready), .target(target),
        .wrap(wrap), .req_count(req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic in plain integers: the true target value, then
    // range test and modulo reduction.
    function automatic longint true_value(input logic m, input longint pc, input longint off);
        longint so;
        if (m) return off * (64'sd1 <<< SHIFT);
        so = (off >= (64'sd1 <<< (OFF_W-1))) ? off - (64'sd1 <<< OFF_W) : off;
        return pc + so * (64'sd1 <<< SHIFT);
    endfunction

    function automatic longint mod_addr(input longint v);
        longint m;
        m = 64'sd1 <<< ADDR_W;
        return ((v % m) + m) % m;
    endfunction

    function automatic bit out_of_range(input longint v);
        return WRAP_EN && ((v < 0) || (v >= (64'sd1 <<< ADDR_W)));
    endfunction

    // Behavioural model: one slot holding the expected result plus a
    // counter of consumed results.
    bit      m_full;
    longint  m_target;
    bit      m_wrap;
    int      m_count;
    longint  tv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full   <= 1'b0;
            m_target <= 0;
            m_wrap   <= 1'b0;
            m_count  <= 0;
        end else begin
            if (m_full && out_ready) begin
                m_count <= (m_count + 1) % 65536;
                m_full  <= 1'b0;
            end
            if (in_valid && (!m_full || out_ready)) begin
                tv        = true_value(mode, longint'(pc_plus4), longint'(offset));
                m_full   <= 1'b1;
                m_target <= mod_addr(tv);
                m_wrap   <= out_of_range(tv);
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", longint'(out_valid), longint'(m_full));
            check("in_ready", longint'(in_ready), longint'(!m_full || out_ready));
            check("req_count", longint'(req_count), longint'(m_count));
            if (m_full) begin
                check("target", longint'(target), m_target);
                check("wrap", longint'(wrap), longint'(m_wrap));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic m, input logic [ADDR_W-1:0] pc, input logic [OFF_W-1:0] off);
        in_valid = 1'b1;
        mode     = m;
        pc_plus4 = pc;
        offset   = off;
    endtask

    // Present one request with the consumer ready; the result must appear
    // right after the next edge.
    task automatic apply(input string name, input logic m, input logic [ADDR_W-1:0] pc,
                         input logic [OFF_W-1:0] off, input logic [ADDR_W-1:0] et, input bit ew);
        drive(m, pc, off);
        out_ready = 1'b1;
        step();
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_target"}, longint'(target), longint'(et));
        check({name, "_wrap"}, longint'(wrap), longint'(ew && WRAP_EN));
    endtask

    typedef struct {
        logic              m;
        logic [ADDR_W-1:0] pc;
        logic [OFF_W-1:0]  off;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        pc_plus4  = '0;
        offset    = '0;
        out_ready = 1'b0;

        #13;
        check("rst_valid", longint'(out_valid), 0);
        check("rst_target", longint'(target), 0);
        check("rst_wrap", longint'(wrap), 0);
        check("rst_count", longint'(req_count), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        #4 rst_n = 1'b1;
        step();
        cmp_en = 1'b1;

        // Hand-computed vectors pinning the arithmetic.
        apply("rel_fwd",  1'b0, 10'h010, 16'h0003, 10'h01C, 1'b0);
        apply("rel_back", 1'b0, 10'h010, 16'hFFFC, 10'h000, 1'b0);
        apply("rel_ovf",  1'b0, 10'h3FC, 16'h0001, 10'h000, 1'b1);
        apply("abs_ovf",  1'b1, 10'h3FF, 16'h0105, 10'h014, 1'b1);
        apply("abs_fit",  1'b1, 10'h000, 16'h0005, 10'h014, 1'b0);
        apply("rel_neg",  1'b0, 10'h004, 16'hFFFE, 10'h3FC, 1'b1);
        in_valid = 1'b0;
        step();
        check("count_after_six", longint'(req_count), 6);
        check("drained", longint'(out_valid), 0);

        // Backpressure: first result must be held while a second waits.
        out_ready = 1'b0;
        drive(1'b0, 10'h100, 16'h0010);
        step();
        drive(1'b1, 10'h000, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_hold_target", longint'(target), 10'h140);
        end
        out_ready = 1'b1;
        step();
        check("bp_second", longint'(target), 10'h080);
        check("bp_count", longint'(req_count), 7);
        drive(1'b0, 10'h200, 16'h0001);
        step();
        check("b2b_target", longint'(target), 10'h204);
        check("b2b_count", longint'(req_count), 8);

        // Mixed directed traffic with an irregular consumer pattern.
        vecs[0] = '{1'b0, 10'h3F0, 16'h0008};
        vecs[1] = '{1'b1, 10'h123, 16'h00FF};
        vecs[2] = '{1'b0, 10'h000, 16'h8000};
        vecs[3] = '{1'b0, 10'h2AA, 16'h7FFF};
        vecs[4] = '{1'b1, 10'h001, 16'hFFFF};
        vecs[5] = '{1'b0, 10'h155, 16'hFFAB};
        vecs[6] = '{1'b1, 10'h3FF, 16'h0000};
        vecs[7] = '{1'b0, 10'h0FC, 16'h0040};
        for (int i = 0; i < 24; i++) begin
            in_valid  = (i % 4) != 3;
            mode      = vecs[i % 8].m;
            pc_plus4  = vecs[i % 8].pc;
            offset    = vecs[i % 8].off;
            out_ready = (i % 3) != 1;
            step();
        end

        // Reset while a result is stalled at the output.
        out_ready = 1'b0;
        drive(1'b0, 10'h020, 16'h0004);
        step();
        check("pre_rst_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_count", longint'(req_count), 0);
        check("mid_rst_target", longint'(target), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_no_xfer", longint'(req_count), 0);
        rst_n = 1'b1;
        drive(1'b0, 10'h040, 16'h0001);
        #1;
        check("post_rst_ready", longint'(in_ready), 1);
        step();
        check("post_rst_valid", longint'(out_valid), 1);
        check("post_rst_target", longint'(target), 10'h044);
        in_valid = 1'b0;
        step();
        check("post_rst_count", longint'(req_count), 1);
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of PC and target address.
REQ-002 SHALL have parameter OFF_W, default 16: width of the immediate offset field.
REQ-003 SHALL have parameter SHIFT, default 2: left shift applied to offset (word to byte).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-008 SHALL have port mode  input  1  0 = PC-relative branch, 1 = absolute jump.
REQ-009 SHALL have port pc_plus4  input  ADDR_W  PC + 4 of the branch instruction.
REQ-010 SHALL have port offset  input  OFF_W  raw immediate from instruction.
REQ-011 SHALL have port out_valid  output  1  target holds a valid result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-013 SHALL have port target  output  ADDR_W  computed target address.
REQ-014 SHALL have port wrap  output  1  result did not fit in ADDR_W bits.
REQ-015 SHALL have port req_count  output  16  number of results accepted by consumer since reset.

Function
REQ-016 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (single-entry output register, full throughput).
REQ-018 SHALL present result on target/out_valid exactly one clk after input transfer.
REQ-019 SHALL, mode 0: target = (pc_plus4 + (sign-extended offset << SHIFT)) mod 2^ADDR_W, sum formed at width ADDR_W+OFF_W+SHIFT+1.
REQ-020 SHALL, mode 1: target = (zero-extended offset << SHIFT) truncated to ADDR_W; pc_plus4 ignored.
REQ-021 SHALL hold target, wrap, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on simultaneous output and input transfer, load the new result and keep out_valid = 1.
REQ-023 SHALL clear out_valid when output transfers with no input transfer in the same cycle.
REQ-024 SHALL increment req_count on each output transfer, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL ignore mode, pc_plus4, offset when no input transfer occurs.

Reset
REQ-026 SHALL, while rst_n = 0, force out_valid = 0, target = 0, wrap = 0, req_count = 0, independent of clk.
REQ-027 SHALL discard any in-flight result on reset mid-operation; no output transfer follows.
REQ-028 SHALL accept a request on the first rising clk edge after rst_n deasserts (in_ready = 1).

Configuration
REQ-029 SHALL, with BTU_WRAP_DETECT_EN defined, set wrap = 1 when mode 0 true signed sum lies outside [0, 2^ADDR_W-1], or mode 1 discarded bits of (offset << SHIFT) are non-zero; wrap registered with target.
REQ-030 SHALL, without BTU_WRAP_DETECT_EN, tie wrap to 0 and omit detection logic; target unaffected.

Verification (defaults ADDR_W=10, OFF_W=16, SHIFT=2, macro defined)
REQ-031 SHALL cover: mode 0, pc_plus4=0x010, offset=0x0003 -> next cycle target=0x01C, wrap=0, out_valid=1.
REQ-032 SHALL cover: mode 0, pc_plus4=0x010, offset=0xFFFC -> target=0x000, wrap=0; pc_plus4=0x3FC, offset=0x0001 -> target=0x000, wrap=1.
REQ-033 SHALL cover: mode 1, offset=0x0105 -> target=0x014, wrap=1; offset=0x0005 -> target=0x014, wrap=0.
REQ-034 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, first target held; out_ready=1 -> back-to-back results, req_count +1 per cycle.
REQ-035 SHALL cover: rst_n low while out_valid=1 -> out_valid=0, req_count=0 immediately; first request after release accepted.
